// File: rtl/keypad_entry_if.sv
// Key-entry bundle between the keypad encoder and its digit consumers.
// The master drives the encoder side (key_d/key_dav). The slave is the entry controller.
interface keypad_entry_if #(
  parameter int NDIGITS = 4
);
  logic [3:0]           key_d;
  logic                 key_dav;
  logic [4*NDIGITS-1:0] digits;
  logic [3:0]           digit_count;
  logic [4*NDIGITS-1:0] entry_value;
  logic [3:0]           entry_len;
  logic                 entry_valid;
  logic                 key_strobe;
  logic                 overflow;
  logic                 timeout;
  logic                 busy;

  modport master (
    output key_d, key_dav,
    input  digits, digit_count, entry_value, entry_len,
    input  entry_valid, key_strobe, overflow, timeout, busy
  );

  modport slave (
    input  key_d, key_dav,
    output digits, digit_count, entry_value, entry_len,
    output entry_valid, key_strobe, overflow, timeout, busy
  );
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Debounced keypad sequencer: accepts each key once and assembles BCD digits into an entry.
// '#' commits the entry. An idle partial entry is discarded after TIMEOUT_CYC cycles.
module keypad_entry_ctrl #(
  parameter int NDIGITS      = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic           clk,
  input  logic           reset,
  keypad_entry_if.slave  kp
);
  localparam int          W        = 4 * NDIGITS;
  localparam logic [7:0]  DEB      = 8'(DEBOUNCE_CYC);
  localparam logic [19:0] TMO_LAST = 20'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  NMAX     = 4'(NDIGITS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, RELEASE} state_t;

  state_t       state;
  logic [3:0]   code_q;
  logic [7:0]   deb_cnt;
  logic [19:0]  timer;
  logic [W-1:0] digits_q, entry_q;
  logic [3:0]   count_q, len_q;
  logic         valid_q, strobe_q, ovf_q, tout_q, busy_q;

  logic [W-1:0] shifted;
  logic [7:0]   deb_nxt;
  logic         key_match;

  // The shift drops the oldest nibble only on a full buffer, which ACCEPT never shifts.
  assign shifted   = (digits_q << 4) | W'(code_q);
  assign deb_nxt   = deb_cnt + 8'd1;
  assign key_match = kp.key_dav && (kp.key_d == code_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RELEASE;
      code_q   <= '0;
      deb_cnt  <= '0;
      timer    <= '0;
      digits_q <= '0;
      entry_q  <= '0;
      count_q  <= '0;
      len_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      tout_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (count_q != 4'd0) begin
            if (timer == TMO_LAST) begin
              digits_q <= '0;
              count_q  <= '0;
              ovf_q    <= 1'b0;
              tout_q   <= 1'b1;
              timer    <= '0;
            end else if (timer != '1) begin
              timer <= timer + 20'd1;
            end
          end
          // A new press still starts debouncing in the same cycle a timeout fires.
          if (kp.key_dav) begin
            code_q  <= kp.key_d;
            deb_cnt <= 8'd1;
            state   <= DEBOUNCE;
            busy_q  <= 1'b1;
          end
        end

        DEBOUNCE: begin
          if (!key_match) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            deb_cnt <= deb_nxt;
            if (deb_nxt == DEB) begin
              state    <= ACCEPT;
              strobe_q <= 1'b1;
            end
          end
        end

        ACCEPT: begin
          if (code_q <= 4'd9) begin
            if (count_q < NMAX) begin
              digits_q <= shifted;
              count_q  <= count_q + 4'd1;
              timer    <= '0;
            end else begin
              ovf_q <= 1'b1;
            end
          end else if (code_q == 4'hF && count_q != 4'd0) begin
            entry_q  <= digits_q;
            len_q    <= count_q;
            valid_q  <= 1'b1;
            digits_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            timer    <= '0;
          end
          state   <= RELEASE;
          deb_cnt <= '0;
          busy_q  <= 1'b1;
        end

        RELEASE: begin
          busy_q <= 1'b1;
          if (kp.key_dav) begin
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_nxt;
            if (deb_nxt == DEB) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end

        default: begin
          state   <= RELEASE;
          deb_cnt <= '0;
        end
      endcase
    end
  end

  assign kp.digits      = digits_q;
  assign kp.digit_count = count_q;
  assign kp.entry_value = entry_q;
  assign kp.entry_len   = len_q;
  assign kp.entry_valid = valid_q;
  assign kp.key_strobe  = strobe_q;
  assign kp.overflow    = ovf_q;
  assign kp.timeout     = tout_q;
  assign kp.busy        = busy_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: entry, glitches, overflow, timeout, held-through-reset.
module tb_keypad_entry_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_entry_if #(.NDIGITS(4)) kp();

  keypad_entry_ctrl #(
    .NDIGITS(4), .DEBOUNCE_CYC(4), .TIMEOUT_CYC(1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .kp(kp)
  );

  int total = 0, bad = 0;
  int cyc = 0, n_stb = 0, n_vld = 0, n_tmo = 0;
  int stb_cyc = 0, vld_cyc = 0, press_cyc = 0;
  int s0, v0, t0;

  always @(posedge clk) cyc++;

  // Pulse monitors: each one-cycle pulse is seen at exactly one falling edge.
  always @(negedge clk) begin
    if (kp.key_strobe)  begin n_stb++; stb_cyc = cyc; end
    if (kp.entry_valid) begin n_vld++; vld_cyc = cyc; end
    if (kp.timeout)     n_tmo++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      kp.key_dav = 1'b0;
      kp.key_d   = 'x;
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold = 8, input int rel = 8);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == 0) press_cyc = cyc;
      kp.key_dav = 1'b1;
      kp.key_d   = code;
    end
    idle(rel);
  endtask

  initial begin
    reset      = 1'b1;
    kp.key_dav = 1'b0;
    kp.key_d   = 'x;
    repeat (3) @(negedge clk);
    chk("rst_digits", kp.digits, 0);
    chk("rst_count", kp.digit_count, 0);
    chk("rst_entry", kp.entry_value, 0);
    chk("rst_len", kp.entry_len, 0);
    chk("rst_flags", {kp.entry_valid, kp.key_strobe, kp.overflow, kp.timeout, kp.busy}, 0);
    reset = 1'b0;
    idle(10);

    // Basic entry 1234#
    s0 = n_stb; v0 = n_vld;
    press(4'h1);
    chk("press_latency", stb_cyc - press_cyc, 4);
    press(4'h2); press(4'h3); press(4'h4);
    chk("digits_1234", kp.digits, 32'h1234);
    chk("count_4", kp.digit_count, 4);
    press(4'hF);
    chk("strobes_5", n_stb - s0, 5);
    chk("valid_once", n_vld - v0, 1);
    chk("valid_after_strobe", vld_cyc - stb_cyc, 1);
    chk("entry_1234", kp.entry_value, 32'h1234);
    chk("len_4", kp.entry_len, 4);
    chk("count_clr", kp.digit_count, 0);
    chk("busy_idle", kp.busy, 0);

    // Short glitch and a code change mid-debounce
    s0 = n_stb;
    press(4'h5, 3, 8);
    chk("glitch_no_strobe", n_stb - s0, 0);
    chk("glitch_count", kp.digit_count, 0);
    repeat (2) begin @(negedge clk); kp.key_dav = 1'b1; kp.key_d = 4'h5; end
    repeat (2) begin @(negedge clk); kp.key_dav = 1'b1; kp.key_d = 4'h6; end
    idle(8);
    chk("chg_no_strobe", n_stb - s0, 0);

    // Overflow on fifth digit, then commit
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
    chk("ovf_count", kp.digit_count, 4);
    chk("ovf_digits", kp.digits, 32'h9876);
    chk("ovf_flag", kp.overflow, 1);
    press(4'hF);
    chk("ovf_entry", kp.entry_value, 32'h9876);
    chk("ovf_len", kp.entry_len, 4);
    chk("ovf_cleared", kp.overflow, 0);

    // Inter-key timeout
    press(4'h7);
    chk("tmo_count1", kp.digit_count, 1);
    t0 = n_tmo;
    kp.key_dav = 1'b0;
    idle(990);
    chk("tmo_not_early", n_tmo - t0, 0);
    chk("tmo_still_held", kp.digits, 32'h7);
    idle(20);
    chk("tmo_once", n_tmo - t0, 1);
    chk("tmo_digits", kp.digits, 0);
    chk("tmo_count0", kp.digit_count, 0);
    v0 = n_vld;
    press(4'hF);
    chk("tmo_no_commit", n_vld - v0, 0);
    chk("entry_holds", kp.entry_value, 32'h9876);

    // Key held through reset
    @(negedge clk);
    reset = 1'b1; kp.key_dav = 1'b1; kp.key_d = 4'h2;
    repeat (3) @(negedge clk);
    chk("rst2_entry", kp.entry_value, 0);
    chk("rst2_len", kp.entry_len, 0);
    reset = 1'b0;
    s0 = n_stb;
    repeat (20) @(negedge clk);
    chk("held_no_strobe", n_stb - s0, 0);
    idle(8);
    press(4'h2);
    chk("held_then_press", n_stb - s0, 1);
    chk("digits_2", kp.digits, 32'h2);
    press(4'hF);
    chk("entry_2", kp.entry_value, 32'h2);
    chk("len_1", kp.entry_len, 1);

    // '#' on empty buffer, then long press
    s0 = n_stb; v0 = n_vld;
    press(4'hF);
    chk("empty_hash_strobe", n_stb - s0, 1);
    chk("empty_hash_novalid", n_vld - v0, 0);
    s0 = n_stb;
    press(4'h3, 50, 8);
    chk("long_one_strobe", n_stb - s0, 1);
    chk("long_digits", kp.digits, 32'h3);
    chk("long_count", kp.digit_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
